button_conditioner: RTL and testbench

Parametrised multi-channel button front end for board push-buttons and switches. Each channel synchronises the raw pad input, applies a tick-qualified stability filter, and produces a clean level plus single-cycle press, release, long-press and auto-repeat pulses. It replaces single-channel two-flop edge detection. It sits between the board I/O pins and the MMIO/keypad logic.

---
 rtl/button_pkg.sv | 19 +
 rtl/button_channel.sv | 149 ++++++++++++++
 rtl/button_conditioner.sv | 57 +++++
 tb/tb_button_conditioner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the multi-channel button front end.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } btn_state_t;

    // Bits needed to hold values 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, tick-qualified debounce and press/hold FSM.
//
// state    | meaning
// RELEASED | debounced level is 0, waiting for an accepted rise
// PRESSED  | level is 1, counting ticks toward the long-press point
// HELD     | long press reported, emitting periodic repeat pulses
module button_channel
    import button_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int DW = cnt_width(DEBOUNCE_TICKS);
    localparam int HW = cnt_width(max_int(LONG_TICKS, REPEAT_TICKS));

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DW-1:0]          db_cnt_q;
    logic                   level_q;
    logic                   accept;
    logic                   rise_acc;
    logic                   fall_acc;

    btn_state_t    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          press_d, release_d, long_d, repeat_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The level flips on the same edge the FSM sees the accepted transition,
    // so level_o and press_o/release_o rise together.
    assign accept   = tick_i && (s != level_q) && (db_cnt_q == DEB_LAST);
    assign rise_acc = accept && !level_q;
    assign fall_acc = accept && level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else if (s == level_q) begin
            db_cnt_q <= '0;
        end else if (tick_i) begin
            if (db_cnt_q == DEB_LAST) begin
                level_q  <= ~level_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            RELEASED: begin
                if (rise_acc) begin
                    state_d = PRESSED;
                    hold_d  = '0;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                // A fall beats a coincident terminal count.
                if (fall_acc) begin
                    state_d   = RELEASED;
                    hold_d    = '0;
                    release_d = 1'b1;
                end else if (tick_i) begin
                    if (hold_q == LONG_LAST) begin
                        state_d = HELD;
                        hold_d  = '0;
                        long_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            HELD: begin
                if (fall_acc) begin
                    state_d   = RELEASED;
                    hold_d    = '0;
                    release_d = 1'b1;
                end else if (tick_i) begin
                    if (hold_q == REPEAT_LAST) begin
                        hold_d   = '0;
                        repeat_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = RELEASED;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RELEASED;
            hold_q    <= '0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_o   <= press_d;
            release_o <= release_d;
            long_o    <= long_d;
            repeat_o  <= repeat_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: N_CH independent channels sharing one tick strobe.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_CH           = 5,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_i,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] repeat_o
);

    if (N_CH < 1) begin : g_bad_n_ch
        $error("button_conditioner: N_CH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_TICKS must be >= 1");
    end
    if (LONG_TICKS < 1) begin : g_bad_long
        $error("button_conditioner: LONG_TICKS must be >= 1");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_TICKS must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .LONG_TICKS    (LONG_TICKS),
            .REPEAT_TICKS  (REPEAT_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick_i),
            .btn_i    (btn_i[i]),
            .level_o  (level_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i]),
            .long_o   (long_o[i]),
            .repeat_o (repeat_o[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses (channel, kind, edge); a negedge monitor matches them.
module tb_button_conditioner;

    localparam int N_CH = 2;

    logic            clk;
    logic            rst;
    logic            tick_i;
    logic [N_CH-1:0] btn_i;
    logic [N_CH-1:0] level_o, press_o, release_o, long_o, repeat_o;

    button_conditioner #(
        .N_CH(N_CH), .SYNC_STAGES(2), .DEBOUNCE_TICKS(4), .LONG_TICKS(10), .REPEAT_TICKS(3)
    ) u_dut (
        .clk(clk), .rst(rst), .tick_i(tick_i), .btn_i(btn_i),
        .level_o(level_o), .press_o(press_o), .release_o(release_o),
        .long_o(long_o), .repeat_o(repeat_o)
    );

    localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_REP = 3;

    typedef struct {
        int ch;
        int kind;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    string kname[4] = '{"press", "release", "long", "repeat"};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc equals the number of the most recent posedge when sampled at negedge.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic logic pulse_of(input int k, input int ch);
        case (k)
            K_PRESS: return press_o[ch];
            K_REL:   return release_o[ch];
            K_LONG:  return long_o[ch];
            default: return repeat_o[ch];
        endcase
    endfunction

    task automatic push(input int ch, input int kind, input int at);
        ev_t e;
        e.ch = ch; e.kind = kind; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        int found;
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int k = 0; k < 4; k++) begin
                if (pulse_of(k, ch) === 1'b1) begin
                    found = -1;
                    foreach (sb[i])
                        if (found < 0 && sb[i].ch == ch && sb[i].kind == k && sb[i].cyc == cyc)
                            found = i;
                    checks++;
                    if (found >= 0) begin
                        sb.delete(found);
                    end else begin
                        failures++;
                        $display("FAIL unexpected_%s ch%0d: pulse seen at edge %0d, required none", kname[k], ch, cyc);
                    end
                end
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_%s ch%0d: no pulse, required at edge %0d", kname[sb[i].kind], sb[i].ch, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        int e0, e1, e2;
        rst    = 1'b0;
        tick_i = 1'b1;
        btn_i  = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {level_o, press_o, release_o, long_o, repeat_o}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press, long, repeats, then a fall coinciding with a repeat terminal count.
        @(negedge clk);
        btn_i[0] = 1'b1;
        e0 = cyc + 1;
        push(0, K_PRESS, e0 + 5);
        push(0, K_LONG,  e0 + 15);
        push(0, K_REP,   e0 + 18);
        push(0, K_REP,   e0 + 21);
        push(0, K_REP,   e0 + 24);
        push(0, K_REP,   e0 + 27);
        push(0, K_REL,   e0 + 30);
        wait_until(e0 + 4);
        chk("press_level_before", level_o, 2'b00);
        wait_until(e0 + 5);
        chk("press_level_after", level_o, 2'b01);
        wait_until(e0 + 24);
        btn_i[0] = 1'b0;
        wait_until(e0 + 29);
        chk("release_level_before", level_o, 2'b01);
        wait_until(e0 + 30);
        chk("release_level_after", level_o, 2'b00);
        repeat (3) @(negedge clk);

        // Three-clock glitch stays just under the debounce threshold.
        @(negedge clk);
        btn_i[0] = 1'b1;
        e0 = cyc + 1;
        repeat (3) @(negedge clk);
        btn_i[0] = 1'b0;
        wait_until(e0 + 8);
        chk("glitch_level", level_o, 2'b00);
        @(negedge clk);
        btn_i[0] = 1'b1;
        e0 = cyc + 1;
        push(0, K_PRESS, e0 + 5);
        wait_until(e0 + 5);
        chk("post_glitch_level", level_o, 2'b01);
        btn_i[0] = 1'b0;
        e1 = cyc + 1;
        push(0, K_REL, e1 + 5);
        wait_until(e1 + 5);
        chk("post_glitch_release", level_o, 2'b00);
        repeat (2) @(negedge clk);

        // Sparse ticks on channel 1: ticks at e0+3, +7, +11, +15.
        @(negedge clk);
        btn_i[1] = 1'b1;
        e0 = cyc + 1;
        tick_i = 1'b0;
        push(1, K_PRESS, e0 + 15);
        for (int ed = e0 + 1; ed <= e0 + 15; ed++) begin
            @(negedge clk);
            tick_i = ((ed - e0) % 4 == 3);
        end
        chk("gated_level_before", level_o, 2'b00);
        @(negedge clk);
        tick_i = 1'b1;
        chk("gated_level_after", level_o, 2'b10);
        btn_i[1] = 1'b0;
        e1 = cyc + 1;
        push(1, K_REL, e1 + 5);
        wait_until(e1 + 5);
        chk("gated_release", level_o, 2'b00);
        repeat (2) @(negedge clk);

        // Async reset while HELD, button kept down through reset.
        @(negedge clk);
        btn_i[0] = 1'b1;
        e0 = cyc + 1;
        push(0, K_PRESS, e0 + 5);
        push(0, K_LONG,  e0 + 15);
        wait_until(e0 + 16);
        chk("held_level", level_o, 2'b01);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", {level_o, press_o, release_o, long_o, repeat_o}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        e2 = cyc + 1;
        push(0, K_PRESS, e2 + 5);
        wait_until(e2 + 4);
        chk("rearm_level_before", level_o, 2'b00);
        wait_until(e2 + 5);
        chk("rearm_level_after", level_o, 2'b01);
        btn_i[0] = 1'b0;
        e1 = cyc + 1;
        push(0, K_REL, e1 + 5);
        wait_until(e1 + 5);
        repeat (2) @(negedge clk);

        // Both channels, channel 1 one clock late; channel 1 release hits a repeat terminal count.
        @(negedge clk);
        btn_i[0] = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        btn_i[1] = 1'b1;
        push(0, K_PRESS, e0 + 5);
        push(1, K_PRESS, e0 + 6);
        push(0, K_LONG,  e0 + 15);
        push(1, K_LONG,  e0 + 16);
        push(0, K_REP,   e0 + 18);
        push(1, K_REP,   e0 + 19);
        push(0, K_REP,   e0 + 21);
        push(0, K_REL,   e0 + 22);
        push(1, K_REL,   e0 + 22);
        wait_until(e0 + 6);
        chk("dual_level", level_o, 2'b11);
        wait_until(e0 + 16);
        btn_i = '0;
        wait_until(e0 + 22);
        chk("dual_release_level", level_o, 2'b00);
        repeat (5) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected pulses left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
